// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
// Module      : regfile_mp
// Description : Parametrised multi-port register file: two prioritised write
//               ports, write-to-read bypass, post-reset clear with ready flag.
//               Optional macro REGFILE_ZERO_REG_EN hardwires register 0 to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_mp #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 16,
    parameter int ADDR_W   = $clog2(NUM_REGS),
    parameter int NUM_RD   = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_RD*ADDR_W-1:0]   SrcReg,
    output logic [NUM_RD*DATA_W-1:0]   SrcData,
    input  logic                       WriteRegA,
    input  logic [ADDR_W-1:0]          DstRegA,
    input  logic [DATA_W-1:0]          DstDataA,
    input  logic                       WriteRegB,
    input  logic [ADDR_W-1:0]          DstRegB,
    input  logic [DATA_W-1:0]          DstDataB,
    output logic                       ready
);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] C_LAST_IDX = ADDR_W'(NUM_REGS - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_clr_ptr;
    logic [ADDR_W-1:0]   w_clr_ptr_nxt;
    logic                r_ready;
    logic                w_ready_nxt;
    logic [DATA_W-1:0]   r_regs [NUM_REGS];
    logic                w_wen_a;
    logic                w_wen_b;

`ifdef REGFILE_ZERO_REG_EN
    assign w_wen_a = WriteRegA && (DstRegA != '0);
    assign w_wen_b = WriteRegB && (DstRegB != '0);
`else
    assign w_wen_a = WriteRegA;
    assign w_wen_b = WriteRegB;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= ST_CLEAR;
            r_clr_ptr <= '0;
            r_ready   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_ptr <= w_clr_ptr_nxt;
            r_ready   <= w_ready_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_clr_ptr_nxt = r_clr_ptr;
        w_ready_nxt   = r_ready;
        case (r_state)
            ST_CLEAR: begin
                w_clr_ptr_nxt = r_clr_ptr + 1'b1;
                if (r_clr_ptr == C_LAST_IDX) begin
                    w_state_nxt   = ST_RUN;
                    w_ready_nxt   = 1'b1;
                    w_clr_ptr_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    // Array holds its contents while rst is low; A is written last so it wins a collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (r_state == ST_CLEAR) begin
                r_regs[r_clr_ptr] <= '0;
            end else begin
                if (w_wen_b) r_regs[DstRegB] <= DstDataB;
                if (w_wen_a) r_regs[DstRegA] <= DstDataA;
            end
        end
    end

    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
        logic [ADDR_W-1:0] w_addr;
        logic [DATA_W-1:0] w_data;

        assign w_addr = SrcReg[gi*ADDR_W +: ADDR_W];

        always_comb begin
            w_data = '0;
            if (r_state == ST_RUN) begin
                if (w_wen_a && (DstRegA == w_addr)) begin
                    w_data = DstDataA;
                end else if (w_wen_b && (DstRegB == w_addr)) begin
                    w_data = DstDataB;
                end else begin
                    w_data = r_regs[w_addr];
                end
`ifdef REGFILE_ZERO_REG_EN
                if (w_addr == '0) w_data = '0;
`endif
            end
        end

        assign SrcData[gi*DATA_W +: DATA_W] = w_data;
    end

    assign ready = r_ready;

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_mp
// Description : Directed self-checking bench for regfile_mp with an
//               expected-value queue; honours REGFILE_ZERO_REG_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_mp;

    localparam int DATA_W   = 16;
    localparam int NUM_REGS = 16;
    localparam int ADDR_W   = 4;
    localparam int NUM_RD   = 2;

    logic                      clk;
    logic                      rst;
    logic [NUM_RD*ADDR_W-1:0]  SrcReg;
    logic [NUM_RD*DATA_W-1:0]  SrcData;
    logic                      WriteRegA;
    logic [ADDR_W-1:0]         DstRegA;
    logic [DATA_W-1:0]         DstDataA;
    logic                      WriteRegB;
    logic [ADDR_W-1:0]         DstRegB;
    logic [DATA_W-1:0]         DstDataB;
    logic                      ready;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q [$];

    regfile_mp #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .NUM_RD   (NUM_RD)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .SrcReg    (SrcReg),
        .SrcData   (SrcData),
        .WriteRegA (WriteRegA),
        .DstRegA   (DstRegA),
        .DstDataA  (DstDataA),
        .WriteRegB (WriteRegB),
        .DstRegB   (DstRegB),
        .DstDataB  (DstDataB),
        .ready     (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input int a0, input int a1);
        SrcReg = {ADDR_W'(a1), ADDR_W'(a0)};
    endtask

    task automatic push(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    function automatic logic [31:0] rd(input int p);
        return 32'(SrcData[p*DATA_W +: DATA_W]);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $error("FAIL %s: scoreboard empty, observed %h", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                bad++;
                $error("FAIL %s: observed %h expected %h", tag, obs, e);
            end
        end
    endtask

    logic [31:0] zero_exp;

    initial begin
`ifdef REGFILE_ZERO_REG_EN
        zero_exp = 32'h0000;
`else
        zero_exp = 32'hFFFF;
`endif
        rst = 1'b0;
        WriteRegA = 1'b0; DstRegA = '0; DstDataA = '0;
        WriteRegB = 1'b0; DstRegB = '0; DstDataB = '0;
        set_rd(0, 0);

        // Reset held for three edges
        repeat (3) tick();
        set_rd(5, 9);
        push(32'h0); push(32'h0); push(32'h0);
        @(negedge clk);
        check("rst_ready", 32'(ready));
        check("rst_rd0", rd(0));
        check("rst_rd1", rd(1));

        // Clear sequence: ready rises after exactly 16 edges with rst=1
        rst = 1'b1;
        for (int k = 1; k <= NUM_REGS; k++) begin
            tick();
            push((k == NUM_REGS) ? 32'h1 : 32'h0);
            if (k == 8) push(32'h0);
            @(negedge clk);
            check($sformatf("clr_ready_%0d", k), 32'(ready));
            if (k == 8) check("clr_rd0", rd(0));
        end

        // Basic write then read
        tick();
        WriteRegA = 1'b1; DstRegA = 4'd5; DstDataA = 16'hBEEF;
        tick();
        WriteRegA = 1'b0;
        set_rd(5, 5);
        push(32'hBEEF); push(32'hBEEF);
        @(negedge clk);
        check("wr5_p0", rd(0));
        check("wr5_p1", rd(1));
        set_rd(6, 5);
        push(32'h0);
        #1;
        check("rd6_zero", rd(0));

        // Bypass A
        tick();
        WriteRegA = 1'b1; DstRegA = 4'd3; DstDataA = 16'h1111;
        tick();
        DstDataA = 16'h2222;
        set_rd(5, 3);
        push(32'hBEEF); push(32'h2222);
        @(negedge clk);
        check("byp_a_p0", rd(0));
        check("byp_a_p1", rd(1));
        tick();
        WriteRegA = 1'b0;
        push(32'h2222);
        #1;
        check("reg3_after", rd(1));

        // Bypass B
        WriteRegB = 1'b1; DstRegB = 4'd9; DstDataB = 16'h3333;
        set_rd(9, 3);
        push(32'h3333);
        @(negedge clk);
        check("byp_b", rd(0));
        tick();
        WriteRegB = 1'b0;
        push(32'h3333);
        #1;
        check("reg9_after", rd(0));

        // Same-index collision: A wins
        WriteRegA = 1'b1; DstRegA = 4'd7; DstDataA = 16'hAAAA;
        WriteRegB = 1'b1; DstRegB = 4'd7; DstDataB = 16'h5555;
        set_rd(7, 7);
        push(32'hAAAA);
        @(negedge clk);
        check("coll_byp", rd(0));
        tick();
        WriteRegA = 1'b0; WriteRegB = 1'b0;
        push(32'hAAAA);
        #1;
        check("coll_reg7", rd(0));

        // Distinct indices: both land
        WriteRegA = 1'b1; DstRegA = 4'd7; DstDataA = 16'hAAAA;
        WriteRegB = 1'b1; DstRegB = 4'd8; DstDataB = 16'h5555;
        tick();
        WriteRegA = 1'b0; WriteRegB = 1'b0;
        set_rd(7, 8);
        push(32'hAAAA); push(32'h5555);
        @(negedge clk);
        check("dual_reg7", rd(0));
        check("dual_reg8", rd(1));

        // Register 0 behaviour depends on the build option
        tick();
        WriteRegA = 1'b1; DstRegA = 4'd0; DstDataA = 16'hFFFF;
        set_rd(0, 5);
        push(zero_exp);
        @(negedge clk);
        check("r0_same", rd(0));
        tick();
        WriteRegA = 1'b0;
        push(zero_exp);
        #1;
        check("r0_next", rd(0));

        // Reset mid-run with writes asserted throughout
        WriteRegA = 1'b1; DstRegA = 4'd5; DstDataA = 16'h0F0F;
        WriteRegB = 1'b1; DstRegB = 4'd9; DstDataB = 16'hF0F0;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        set_rd(5, 9);
        push(32'h0); push(32'h0); push(32'h0);
        @(negedge clk);
        check("mrst_ready", 32'(ready));
        check("mrst_rd0", rd(0));
        check("mrst_rd1", rd(1));
        for (int k = 1; k <= NUM_REGS; k++) begin
            DstRegA = ADDR_W'(k - 1);
            DstRegB = ADDR_W'(NUM_REGS - k);
            tick();
            if (k == NUM_REGS) begin
                WriteRegA = 1'b0;
                WriteRegB = 1'b0;
            end
            push((k == NUM_REGS) ? 32'h1 : 32'h0);
            @(negedge clk);
            check($sformatf("mclr_ready_%0d", k), 32'(ready));
        end
        for (int r = 0; r < NUM_REGS; r += 2) begin
            set_rd(r, r + 1);
            push(32'h0); push(32'h0);
            #1;
            check($sformatf("post_reg%0d", r), rd(0));
            check($sformatf("post_reg%0d", r + 1), rd(1));
        end

        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $error("FAIL scoreboard_drain: observed %0d left expected 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
